// File: rtl/gf16_horner_eval_pkg.sv
// Shared definitions for the GF(2^4) Horner polynomial evaluator:
// symbol width, field reduction constant and controller state encoding.
package gf16_horner_eval_pkg;

    localparam int GF_W = 4;

    // Low terms of the primitive polynomial x^4 + x + 1
    localparam logic [GF_W-1:0] GF_PRIM = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : gf16_horner_eval_pkg

// File: rtl/gf16_add.sv
// GF(2^4) adder: field addition is a carry-free bitwise XOR.
module gf16_add
    import gf16_horner_eval_pkg::*;
(
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    output logic [GF_W-1:0] o_s
);

    assign o_s = i_a ^ i_b;

endmodule : gf16_add

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier, product reduced modulo x^4 + x + 1.
module gf16_mul
    import gf16_horner_eval_pkg::*;
(
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    output logic [GF_W-1:0] o_p
);

    logic [GF_W-1:0] w_sh;
    logic [GF_W-1:0] w_acc;

    // Shift-and-add: w_sh walks through i_a * x^i, reduced at every step
    always_comb begin
        w_acc = {GF_W{1'b0}};
        w_sh  = i_a;
        for (int i = 0; i < GF_W; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_sh;
            end else begin
                w_acc = w_acc;
            end
            w_sh = {w_sh[GF_W-2:0], 1'b0} ^ (w_sh[GF_W-1] ? GF_PRIM : {GF_W{1'b0}});
        end
        o_p = w_acc;
    end

endmodule : gf16_mul

// File: rtl/gf16_horner_eval.sv
// Streaming Horner evaluator: P(x_pt) over GF(2^4) from a coefficient stream
// delivered highest degree first, result presented with a valid/ready handshake.
module gf16_horner_eval
    import gf16_horner_eval_pkg::state_e;
    import gf16_horner_eval_pkg::ST_IDLE;
    import gf16_horner_eval_pkg::ST_ACCUM;
    import gf16_horner_eval_pkg::ST_DONE;
#(
    parameter int GF_W  = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [GF_W-1:0]  x_pt,
    input  logic             coef_valid,
    input  logic [GF_W-1:0]  coef_data,
    output logic             coef_ready,
    output logic             res_valid,
    output logic [GF_W-1:0]  res_data,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [GF_W-1:0]  SYM_ZERO = {GF_W{1'b0}};

    state_e           r_state;
    state_e           w_state_nxt;
    logic [GF_W-1:0]  r_acc;
    logic [GF_W-1:0]  w_acc_nxt;
    logic [GF_W-1:0]  r_x;
    logic [GF_W-1:0]  w_x_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;

    logic             r_coef_ready;
    logic             r_res_valid;
    logic [GF_W-1:0]  r_res_data;
    logic             r_busy;
    logic             w_res_valid_nxt;
    logic [GF_W-1:0]  w_res_data_nxt;

    logic [GF_W-1:0]  w_prod;
    logic [GF_W-1:0]  w_sum;
    logic             w_accept;
    logic             w_res_hs;

    gf16_mul u_mul (
        .i_a (r_acc),
        .i_b (r_x),
        .o_p (w_prod)
    );

    gf16_add u_add (
        .i_a (w_prod),
        .i_b (coef_data),
        .o_s (w_sum)
    );

    assign w_accept = (r_state == ST_ACCUM) && coef_valid;
    assign w_res_hs = r_res_valid && res_ready;

    // Next-state, accumulator and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_x_nxt     = r_x;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt = SYM_ZERO;
                    w_x_nxt   = x_pt;
                    w_cnt_nxt = len;
                    if (len != CNT_ZERO) begin
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum;
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (w_res_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = SYM_ZERO;
                w_x_nxt     = SYM_ZERO;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Result is offered from the cycle after DONE is entered and withdrawn with the handshake
    always_comb begin
        w_res_valid_nxt = 1'b0;
        w_res_data_nxt  = SYM_ZERO;
        if ((r_state == ST_DONE) && !w_res_hs) begin
            w_res_valid_nxt = 1'b1;
            w_res_data_nxt  = r_acc;
        end else begin
            w_res_valid_nxt = 1'b0;
            w_res_data_nxt  = SYM_ZERO;
        end
    end

    // All evaluator state plus the registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= SYM_ZERO;
            r_x          <= SYM_ZERO;
            r_cnt        <= CNT_ZERO;
            r_coef_ready <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= SYM_ZERO;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_x          <= w_x_nxt;
            r_cnt        <= w_cnt_nxt;
            r_coef_ready <= (w_state_nxt == ST_ACCUM);
            r_res_valid  <= w_res_valid_nxt;
            r_res_data   <= w_res_data_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign coef_ready = r_coef_ready;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = r_busy;

endmodule : gf16_horner_eval

// File: tb/tb_gf16_horner_eval.sv
// Scoreboard bench for gf16_horner_eval: directed cases plus randomized
// transactions checked against a power-sum reference model of P(x).
module tb_gf16_horner_eval;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic [3:0] x_pt;
    logic       coef_valid;
    logic [3:0] coef_data;
    logic       coef_ready;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int n_starts = 0;
    int n_results = 0;
    int rdy_mode = 1;          // 0 random, 1 always ready, 2 never ready
    int last_res = -1;
    logic [3:0] exp_q[$];
    logic [3:0] coefs[16];

    gf16_horner_eval #(.GF_W(4), .LEN_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .x_pt       (x_pt),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference field multiply: carry-less product, then long division by 0x13
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (int'(a) << i);
        for (int k = 6; k >= 4; k--)
            if (((p >> k) & 1) == 1) p = p ^ (32'h13 << (k - 4));
        return 4'(p);
    endfunction

    // P(x) = XOR_i coefs[i] * x^(n-1-i), evaluated term by term
    function automatic logic [3:0] ref_eval(input int n, input logic [3:0] x);
        logic [3:0] acc;
        logic [3:0] term;
        acc = 4'h0;
        for (int i = 0; i < n; i++) begin
            term = coefs[i];
            for (int j = 0; j < n - 1 - i; j++) term = ref_mul(term, x);
            acc = acc ^ term;
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       res_ready = 1'($urandom % 2);
            1:       res_ready = 1'b1;
            default: res_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every result handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    last_res = int'(res_data);
                    chk("res_data", int'(res_data), int'(exp_q.pop_front()));
                end
            end else if (!res_valid) begin
                chk("res_data_zero_when_invalid", int'(res_data), 0);
            end
        end
    end

    // Called right after a posedge (+#1); returns cycles from start edge to res_valid
    task automatic run_eval(input int l, input logic [3:0] x, input int gap_pct,
                            input int stall, output int lat);
        int idx;
        int guard;
        int stalled;
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
        exp_q.push_back(ref_eval(l, x));
        n_starts++;
        start = 1'b1;
        len   = 4'(l);
        x_pt  = x;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'($urandom);
        x_pt  = 4'($urandom);
        lat = 0;
        idx = 0;
        stalled = 0;
        guard = 0;
        while (idx < l && guard < 500) begin
            if (idx == 1 && stalled < stall) begin
                coef_valid = 1'b0;
                stalled++;
            end else begin
                coef_valid = ($urandom % 100) >= gap_pct;
            end
            coef_data = coef_valid ? coefs[idx] : 4'($urandom);
            start = 1'($urandom % 2);
            @(negedge clk);
            if (stall > 0 && idx == 1 && !coef_valid) chk("coef_ready_in_stall", int'(coef_ready), 1);
            if (coef_valid && coef_ready) idx++;
            @(posedge clk); #1;
            lat++;
            guard++;
        end
        start = 1'b0;
        coef_valid = 1'b0;
        coef_data = 4'($urandom);
        guard = 0;
        while (!res_valid && guard < 100) begin
            @(posedge clk); #1;
            lat++;
            guard++;
        end
        if (!res_valid) chk("res_valid_timeout", 0, 1);
        if (gap_pct == 0 && stall == 0) chk("latency", lat, l + 1);
    endtask

    initial begin
        int lat;
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        len = 4'h0;
        x_pt = 4'h0;
        coef_valid = 1'b0;
        coef_data = 4'h0;
        res_ready = 1'b0;
        #3;
        chk("rst_coef_ready", int'(coef_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // x=2, 1,0,0 -> x^2 = 4
        coefs[0] = 4'h1; coefs[1] = 4'h0; coefs[2] = 4'h0;
        run_eval(3, 4'h2, 0, 0, lat);
        @(posedge clk); #1;
        chk("x2_len3", last_res, 4'h4);

        // x=8 -> 8^2 reduces to 0xC
        run_eval(3, 4'h8, 0, 0, lat);
        @(posedge clk); #1;
        chk("x8_len3", last_res, 4'hC);

        // x=3, 1,1 with a 3-cycle stall -> 3^1 = 2
        coefs[0] = 4'h1; coefs[1] = 4'h1;
        run_eval(2, 4'h3, 0, 3, lat);
        @(posedge clk); #1;
        chk("x3_len2_stall", last_res, 4'h2);

        // len=0 with the consumer holding off
        @(negedge clk); rdy_mode = 2;
        run_eval(0, 4'h7, 0, 0, lat);
        for (int k = 0; k < 5; k++) begin
            start = 1'(k % 2);
            len   = 4'h3;
            @(posedge clk); #1;
            chk("len0_valid_hold", int'(res_valid), 1);
            chk("len0_data_hold", int'(res_data), 0);
        end
        start = 1'b0;
        @(negedge clk); rdy_mode = 1;
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'h5;
        x_pt  = 4'h1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_handshake_busy", int'(busy), 0);
        chk("start_in_handshake_ready", int'(coef_ready), 0);
        @(posedge clk); #1;
        chk("start_in_handshake_busy2", int'(busy), 0);

        // Reset in the middle of an evaluation
        start = 1'b1; len = 4'h3; x_pt = 4'h6;
        @(posedge clk); #1;
        start = 1'b0;
        coef_valid = 1'b1; coef_data = 4'h7;
        @(posedge clk); #1;
        coef_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_coef_ready", int'(coef_ready), 0);
        chk("async_rst_res_valid", int'(res_valid), 0);
        chk("async_rst_res_data", int'(res_data), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        coefs[0] = 4'h5;
        run_eval(1, 4'h2, 0, 0, lat);
        @(posedge clk); #1;
        chk("after_reset_x2_len1", last_res, 4'h5);

        // Randomized transactions with valid and ready gaps
        @(negedge clk); rdy_mode = 0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) coefs[i] = 4'($urandom);
            run_eval(int'($urandom_range(0, 15)), 4'($urandom), 30, 0, lat);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("one_result_per_start", n_results, n_starts);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gf16_horner_eval

// File: doc/gf16_horner_eval.md
GF16_HORNER_EVAL -- requirements
Module: gf16_horner_eval

Interface
REQ-001 SHALL have parameter: GF_W, 4, symbol width in bits (GF(2^4)).
REQ-002 SHALL have parameter: LEN_W, 4, width of coefficient-count field (max 15 coefficients).
REQ-003 SHALL have port: clk  input  1  single system clock, rising-edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  begin evaluation; sampled only in IDLE.
REQ-006 SHALL have port: len  input  LEN_W  number of coefficients, latched at accepted start.
REQ-007 SHALL have port: x_pt  input  GF_W  evaluation point, latched at accepted start.
REQ-008 SHALL have port: coef_valid  input  1  coefficient stream valid, highest degree first.
REQ-009 SHALL have port: coef_data  input  GF_W  coefficient symbol.
REQ-010 SHALL have port: coef_ready  output  1  block accepts a coefficient this cycle.
REQ-011 SHALL have port: res_valid  output  1  result available.
REQ-012 SHALL have port: res_data  output  GF_W  P(x_pt).
REQ-013 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 IDLE SHALL transition to ACCUM on start=1 with len!=0, latching len, x_pt and clearing accumulator to 0.
REQ-017 IDLE with start=1 and len=0 SHALL transition to DONE with accumulator 0.
REQ-018 coef_ready SHALL be 1 only in ACCUM; coefficient accepted when coef_valid&coef_ready.
REQ-019 On each accept, accumulator SHALL update to gf_mul(acc, x_pt) XOR coef_data, in the same edge (one coefficient per cycle max).
REQ-020 gf_mul SHALL be polynomial multiply modulo x^4+x+1; addition SHALL be bitwise XOR (GF(2^4) add).
REQ-021 A down-counter loaded with len SHALL decrement per accept; accept at count 1 SHALL transition ACCUM->DONE.
REQ-022 coef_valid=0 in ACCUM SHALL hold accumulator, counter and state (stall indefinitely).
REQ-023 DONE SHALL assert res_valid=1 with res_data=accumulator, held stable until res_ready=1.
REQ-024 DONE with res_ready=1 SHALL transition to IDLE next edge; start in that cycle SHALL be ignored.
REQ-025 start in ACCUM or DONE SHALL be ignored; len/x_pt changes after accepted start SHALL have no effect.
REQ-026 coef_valid in IDLE or DONE SHALL be ignored (not consumed).
REQ-027 Latency: with coef_valid continuously high, res_valid SHALL rise len+1 cycles after the start edge.
REQ-028 res_data SHALL read 0 whenever res_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, accumulator 0, counter 0, coef_ready=0, res_valid=0, res_data=0, busy=0.
REQ-030 Reset asserted mid-ACCUM or mid-DONE SHALL abort the evaluation; no result emitted after release.
REQ-031 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package SHALL hold GF_W, primitive polynomial constant 4'b0011 (x^4+x+1 low terms) and the FSM state enum.
REQ-033 GF addition SHALL reuse the team's existing 4-bit GF adder block; one new sub-module gf16_mul (combinational, 4x4 -> 4) SHALL be instantiated.
REQ-034 All state SHALL be in a single clk/rst_n always block; no latches, no derived clocks.

Verification
REQ-035 x_pt=2, len=3, coefs 1,0,0 back-to-back -> res_valid 4 cycles after start, res_data=4'h4.
REQ-036 x_pt=8, len=3, coefs 1,0,0 -> res_data=4'hC (reduction path exercised).
REQ-037 x_pt=3, len=2, coefs 1,1 with coef_valid low 3 cycles between them -> res_data=4'h2, coef_ready held high during stall.
REQ-038 start with len=0 -> DONE next cycle, res_data=0; hold res_ready=0 for 5 cycles -> res_valid/res_data stable; start pulses ignored.
REQ-039 Assert rst_n=0 after 1 of 3 coefficients -> all outputs 0 asynchronously; new start x_pt=2, len=1, coef 5 -> res_data=4'h5.
REQ-040 Random len/x_pt/coefs with random valid/ready gaps vs. reference model -> every res_data matches, exactly one result per start.
